// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the serializer and its neighbours:
//   - ser_state_e : FSM state encoding for the parallel-to-serial shifter
//   - PAR_EVEN / PAR_ODD : parity-type selector values
//   - calc_parity : parity of a word (up to 32 bits) for a given parity type
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ser_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Narrower words are zero-extended by the caller. Zero bits do not change
  // the XOR reduction, so one 32-bit helper serves every legal width.
  function automatic logic calc_parity(input logic [31:0] word,
                                       input logic        par_typ);
    return (^word) ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/par_serializer.sv
// -----------------------------------------------------------------------------
// par_serializer
// Loads a parallel word and shifts it out one bit per enabled clock. The bit
// order is selectable. The parity bit of the word is captured when it loads.
//
// Parameters:
//   DATA_WIDTH : word width in bits (2..32)
//   MSB_FIRST  : 0 = LSB sent first, 1 = MSB sent first
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   asynchronous reset, active low
//   P_DATA     in   parallel word to send
//   data_valid in   load request (accepted when ready)
//   ready      out  block can accept a word this cycle (IDLE or DONE)
//   ser_en     in   shift enable; low stalls the shifter
//   PAR_TYP    in   parity type, 0 even / 1 odd (sampled at load)
//   ser_data   out  registered serial bit
//   ser_done   out  one-cycle pulse after the last bit
//   busy       out  word in flight (SHIFT)
//   par_bit    out  parity of the latched word
// -----------------------------------------------------------------------------
module par_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  output logic                  ready,
  input  logic                  ser_en,
  input  logic                  PAR_TYP,
  output logic                  ser_data,
  output logic                  ser_done,
  output logic                  busy,
  output logic                  par_bit
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  ser_state_e            state;
  ser_state_e            next_state;
  logic                  load;
  logic                  shift;
  logic                  clear_out;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and datapath strobes. A load in DONE goes straight back
  // to SHIFT, so words can follow each other with no idle gap. ser_en and
  // data_valid are only looked at in the states where they mean something.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift      = 1'b0;
    clear_out  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (data_valid) begin
          load       = 1'b1;
          next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ser_en) begin
          shift = 1'b1;
          if (bit_cnt == LAST_IDX) begin
            next_state = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (data_valid) begin
          load       = 1'b1;
          next_state = ST_SHIFT;
        end else begin
          clear_out  = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Shifter, bit counter and output bit. A load does not touch ser_data.
  // On a back-to-back load the last bit of the previous word stays visible
  // until the first bit of the new word is shifted out. The register shifts
  // toward the bit that is sent, so the next bit is always at a fixed end.
  // The counter stops at DATA_WIDTH because shifting ends in DONE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      ser_data  <= 1'b0;
      par_bit   <= 1'b0;
    end else if (load) begin
      shift_reg <= P_DATA;
      bit_cnt   <= '0;
      par_bit   <= calc_parity(32'(P_DATA), PAR_TYP);
    end else if (shift) begin
      if (MSB_FIRST) begin
        ser_data  <= shift_reg[DATA_WIDTH-1];
        shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
      end else begin
        ser_data  <= shift_reg[0];
        shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
      end
      bit_cnt <= bit_cnt + 1'b1;
    end else if (clear_out) begin
      ser_data <= 1'b0;
    end
  end

  // The status outputs decode the registered state. DONE lasts exactly one
  // cycle, so ser_done is a single-cycle pulse.
  assign ready    = (state != ST_SHIFT);
  assign busy     = (state == ST_SHIFT);
  assign ser_done = (state == ST_DONE);

endmodule

// File: tb/tb_par_serializer.sv
// -----------------------------------------------------------------------------
// tb_par_serializer
// Directed bench for par_serializer. It uses three instances:
//   dut_lsb : DATA_WIDTH=8,  LSB first
//   dut_msb : DATA_WIDTH=8,  MSB first
//   dut_w16 : DATA_WIDTH=16, LSB first
// Each scenario task drives one instance and compares against hand-computed
// bit streams. The stream constants are written in emission order, so the
// first bit sent is the leftmost digit.
// -----------------------------------------------------------------------------
module tb_par_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ser_en = 1'b0;
  logic        par_typ = 1'b0;

  logic [7:0]  p_data8 = 8'h00;
  logic        dv_lsb = 1'b0;
  logic        dv_msb = 1'b0;
  logic [15:0] p_data16 = 16'h0000;
  logic        dv16 = 1'b0;

  logic ready_l, ser_l, done_l, busy_l, par_l;
  logic ready_m, ser_m, done_m, busy_m, par_m;
  logic ready_w, ser_w, done_w, busy_w, par_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  par_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .CLK(clk), .RST(rst_n), .P_DATA(p_data8), .data_valid(dv_lsb),
    .ready(ready_l), .ser_en(ser_en), .PAR_TYP(par_typ), .ser_data(ser_l),
    .ser_done(done_l), .busy(busy_l), .par_bit(par_l)
  );

  par_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .CLK(clk), .RST(rst_n), .P_DATA(p_data8), .data_valid(dv_msb),
    .ready(ready_m), .ser_en(ser_en), .PAR_TYP(par_typ), .ser_data(ser_m),
    .ser_done(done_m), .busy(busy_m), .par_bit(par_m)
  );

  par_serializer #(.DATA_WIDTH(16), .MSB_FIRST(1'b0)) dut_w16 (
    .CLK(clk), .RST(rst_n), .P_DATA(p_data16), .data_valid(dv16),
    .ready(ready_w), .ser_en(ser_en), .PAR_TYP(par_typ), .ser_data(ser_w),
    .ser_done(done_w), .busy(busy_w), .par_bit(par_w)
  );

  // Advance one clock. Outputs are sampled and inputs driven 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({ser_l, done_l, busy_l, par_l, ready_l} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got ser/done/busy/par/ready=%b expected 00001",
               {ser_l, done_l, busy_l, par_l, ready_l});
    end
    step();
    step();
    rst_n = 1'b1;
    ser_en = 1'b1;
    step();
    checks++;
    if ({ser_l, done_l, busy_l, ready_l} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL idle_ignores_ser_en: got ser/done/busy/ready=%b expected 0001",
               {ser_l, done_l, busy_l, ready_l});
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] stream;
    stream = 8'b10100101;
    p_data8 = 8'hA5; par_typ = 1'b0; ser_en = 1'b1; dv_lsb = 1'b1;
    step();
    dv_lsb = 1'b0;
    checks++;
    if ({busy_l, ready_l, ser_l} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL lsb_load: got busy/ready/ser=%b expected 100", {busy_l, ready_l, ser_l});
    end
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (ser_l !== stream[7-k]) begin
        errors++;
        $display("[TB] FAIL lsb_bit%0d: got %b expected %b", k, ser_l, stream[7-k]);
      end
      checks++;
      if (done_l !== (k == 7)) begin
        errors++;
        $display("[TB] FAIL lsb_done_at%0d: got %b expected %b", k, done_l, (k == 7));
      end
    end
    step();
    checks++;
    if ({done_l, ser_l, busy_l, ready_l} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL lsb_back_idle: got done/ser/busy/ready=%b expected 0001",
               {done_l, ser_l, busy_l, ready_l});
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] words [2];
    logic [7:0] streams [2];
    words[0] = 8'hA5; streams[0] = 8'b10100101;
    words[1] = 8'h0F; streams[1] = 8'b00001111;
    ser_en = 1'b1;
    for (int w = 0; w < 2; w++) begin
      p_data8 = words[w]; dv_msb = 1'b1;
      step();
      dv_msb = 1'b0;
      for (int k = 0; k < 8; k++) begin
        step();
        checks++;
        if (ser_m !== streams[w][7-k]) begin
          errors++;
          $display("[TB] FAIL msb_word%0d_bit%0d: got %b expected %b", w, k, ser_m, streams[w][7-k]);
        end
      end
      checks++;
      if (done_m !== 1'b1) begin
        errors++;
        $display("[TB] FAIL msb_word%0d_done: got %b expected 1", w, done_m);
      end
      step();
    end
  endtask

  task automatic test_stall();
    logic [7:0] stream;
    int done_count;
    stream = 8'b10100101;
    done_count = 0;
    p_data8 = 8'hA5; ser_en = 1'b1; dv_lsb = 1'b1;
    step();
    dv_lsb = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (done_l) done_count++;
      checks++;
      if (ser_l !== stream[7-k]) begin
        errors++;
        $display("[TB] FAIL stall_bit%0d: got %b expected %b", k, ser_l, stream[7-k]);
      end
      if (k == 2) begin
        ser_en = 1'b0;
        for (int s = 0; s < 3; s++) begin
          step();
          if (done_l) done_count++;
          checks++;
          if ({ser_l, busy_l} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL stall_hold%0d: got ser/busy=%b expected 11", s, {ser_l, busy_l});
          end
        end
        ser_en = 1'b1;
      end
    end
    step();
    if (done_l) done_count++;
    checks++;
    if (done_count != 1) begin
      errors++;
      $display("[TB] FAIL stall_done_count: got %0d expected 1", done_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] stream;
    stream = 8'b00111100;
    p_data8 = 8'hA5; ser_en = 1'b1; dv_lsb = 1'b1;
    step();
    dv_lsb = 1'b0;
    for (int k = 0; k < 8; k++) step();
    checks++;
    if ({done_l, ser_l} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL b2b_first_done: got done/ser=%b expected 11", {done_l, ser_l});
    end
    p_data8 = 8'h3C; dv_lsb = 1'b1;
    step();
    checks++;
    if ({busy_l, ready_l, done_l, ser_l} !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL b2b_reload: got busy/ready/done/ser=%b expected 1001",
               {busy_l, ready_l, done_l, ser_l});
    end
    p_data8 = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 3) dv_lsb = 1'b0;
      checks++;
      if (ser_l !== stream[7-k]) begin
        errors++;
        $display("[TB] FAIL b2b_bit%0d: got %b expected %b", k, ser_l, stream[7-k]);
      end
    end
    step();
    checks++;
    if ({ser_l, ready_l, busy_l} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL b2b_idle: got ser/ready/busy=%b expected 010", {ser_l, ready_l, busy_l});
    end
  endtask

  task automatic test_parity();
    p_data8 = 8'h07; par_typ = 1'b0; ser_en = 1'b1; dv_lsb = 1'b1;
    step();
    dv_lsb = 1'b0;
    checks++;
    if (par_l !== 1'b1) begin
      errors++;
      $display("[TB] FAIL parity_even: got %b expected 1", par_l);
    end
    par_typ = 1'b1;
    for (int k = 0; k < 9; k++) step();
    checks++;
    if (par_l !== 1'b1) begin
      errors++;
      $display("[TB] FAIL parity_hold: got %b expected 1", par_l);
    end
    dv_lsb = 1'b1;
    step();
    dv_lsb = 1'b0;
    checks++;
    if (par_l !== 1'b0) begin
      errors++;
      $display("[TB] FAIL parity_odd: got %b expected 0", par_l);
    end
    for (int k = 0; k < 9; k++) step();
  endtask

  task automatic test_reset_mid_shift();
    p_data8 = 8'hFF; par_typ = 1'b1; ser_en = 1'b1; dv_lsb = 1'b1;
    step();
    dv_lsb = 1'b0;
    for (int k = 0; k < 5; k++) step();
    checks++;
    if ({ser_l, par_l, busy_l} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL rst_pre: got ser/par/busy=%b expected 111", {ser_l, par_l, busy_l});
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({ser_l, done_l, busy_l, par_l, ready_l} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL rst_async: got ser/done/busy/par/ready=%b expected 00001",
               {ser_l, done_l, busy_l, par_l, ready_l});
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (done_l !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rst_no_done%0d: got %b expected 0", k, done_l);
      end
    end
    rst_n = 1'b1;
    p_data8 = 8'hA5; par_typ = 1'b0; dv_lsb = 1'b1;
    step();
    dv_lsb = 1'b0;
    checks++;
    if ({busy_l, ready_l} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL rst_resume_load: got busy/ready=%b expected 10", {busy_l, ready_l});
    end
    step();
    checks++;
    if (ser_l !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_resume_bit0: got %b expected 1", ser_l);
    end
    for (int k = 0; k < 8; k++) step();
  endtask

  task automatic test_wide();
    logic [15:0] stream;
    stream = 16'b1010010111000011;
    p_data16 = 16'hC3A5; par_typ = 1'b0; ser_en = 1'b1; dv16 = 1'b1;
    step();
    dv16 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      checks++;
      if (ser_w !== stream[15-k]) begin
        errors++;
        $display("[TB] FAIL w16_bit%0d: got %b expected %b", k, ser_w, stream[15-k]);
      end
      checks++;
      if (done_w !== (k == 15)) begin
        errors++;
        $display("[TB] FAIL w16_done_at%0d: got %b expected %b", k, done_w, (k == 15));
      end
    end
    step();
    checks++;
    if ({done_w, ser_w, ready_w} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL w16_idle: got done/ser/ready=%b expected 001", {done_w, ser_w, ready_w});
    end
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_stall();
    test_back_to_back();
    test_parity();
    test_reset_mid_shift();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
